// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache onto a single-ported RAM with data priority.
// Optional instruction anti-starvation counter enabled by defining ARB_ANTI_STARVE_EN.
module cache_mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   ram_err_reg, ram_err_next;
    logic   dreq;
    logic   d_done, i_done;
    logic   i_first;

    assign dreq   = dREN | dWEN;
    assign d_done = (state_reg == DGNT) && (ramstate == RAM_ACCESS);
    assign i_done = (state_reg == IGNT) && (ramstate == RAM_ACCESS);

`ifdef ARB_ANTI_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] starve_reg, starve_next;

    // Counts back-to-back data completions that happened while an instruction fetch waited.
    always_comb begin
        starve_next = starve_reg;
        if (i_done) begin
            starve_next = '0;
        end else if (d_done) begin
            if (!iREN)
                starve_next = '0;
            else if (starve_reg != CNT_W'(STARVE_LIM))
                starve_next = starve_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_reg <= '0;
        else
            starve_reg <= starve_next;
    end

    assign i_first = iREN && (starve_reg == CNT_W'(STARVE_LIM));
`else
    logic unused_starve_lim;
    assign unused_starve_lim = (STARVE_LIM > 0);
    assign i_first           = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg   <= IDLE;
            ram_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ram_err_reg <= ram_err_next;
        end
    end

    assign ram_err = ram_err_reg;

    always_comb begin
        state_next   = state_reg;
        ram_err_next = ram_err_reg;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (state_reg)
            IDLE: begin
                if (i_first)
                    state_next = IGNT;
                else if (dreq)
                    state_next = DGNT;
                else if (iREN)
                    state_next = IGNT;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (ramstate == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    state_next = IDLE;
                end else if (!dreq) begin
                    state_next = IDLE;
                end
                if (ramstate == RAM_ERROR)
                    ram_err_next = 1'b1;
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (ramstate == RAM_ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    state_next = IDLE;
                end else if (!iREN) begin
                    state_next = IDLE;
                end
                if (ramstate == RAM_ERROR)
                    ram_err_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_cache_mem_arbiter;

    localparam int W   = 32;
    localparam int LIM = 4;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
`ifdef ARB_ANTI_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         nRST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic [1:0]   ramstate;
    logic         iwait, dwait, ramREN, ramWEN, ram_err;
    logic [W-1:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cache_mem_arbiter #(.WORD_W(W), .STARVE_LIM(LIM)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        ramstate = FREE;
    endtask

    task automatic go_idle;
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset;
        nRST = 0;
        iREN = 1; dREN = 1; dWEN = 1; iaddr = 32'h40; daddr = 32'h99; dstore = 32'h55;
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #3;
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL reset_iwait: got %b expected 1", iwait); end
        n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL reset_dwait: got %b expected 1", dwait); end
        n_checks++; if (iload !== '0) begin n_fail++; $display("FAIL reset_iload: got %h expected 0", iload); end
        n_checks++; if (dload !== '0) begin n_fail++; $display("FAIL reset_dload: got %h expected 0", dload); end
        n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {ramREN, ramWEN}); end
        n_checks++; if (ramaddr !== '0) begin n_fail++; $display("FAIL reset_ramaddr: got %h expected 0", ramaddr); end
        n_checks++; if (ramstore !== '0) begin n_fail++; $display("FAIL reset_ramstore: got %h expected 0", ramstore); end
        n_checks++; if (ram_err !== 1'b0) begin n_fail++; $display("FAIL reset_ram_err: got %b expected 0", ram_err); end
        dREN = 0; dWEN = 0;
        @(negedge CLK);
        nRST = 1;
        tick();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL first_fetch_ren: got %b expected 1", ramREN); end
        n_checks++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL first_fetch_addr: got %h expected 40", ramaddr); end
        n_checks++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL first_fetch_iwait: got %b expected 0", iwait); end
        n_checks++; if (iload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL first_fetch_iload: got %h expected deadbeef", iload); end
        $display("test_reset: reset values and first fetch checked");
        go_idle();
    endtask

    task automatic test_priority;
        iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h100; ramstate = BUSY;
        tick();
        n_checks++; if (ramaddr !== 32'h100 || ramREN !== 1'b1) begin n_fail++; $display("FAIL prio_dgnt: got addr %h ren %b expected 100/1", ramaddr, ramREN); end
        n_checks++; if ({iwait, dwait} !== 2'b11) begin n_fail++; $display("FAIL prio_c1_waits: got %b expected 11", {iwait, dwait}); end
        tick();
        n_checks++; if ({iwait, dwait} !== 2'b11) begin n_fail++; $display("FAIL prio_c2_waits: got %b expected 11", {iwait, dwait}); end
        tick();
        ramstate = ACCESS; ramload = 32'hA5A5_0001;
        #1;
        n_checks++; if (dwait !== 1'b0 || dload !== 32'hA5A5_0001) begin n_fail++; $display("FAIL prio_c3_done: got dwait %b dload %h expected 0/a5a50001", dwait, dload); end
        n_checks++; if (iwait !== 1'b1 || iload !== '0) begin n_fail++; $display("FAIL prio_c3_iwait: got iwait %b iload %h expected 1/0", iwait, iload); end
        tick();
        dREN = 0; ramstate = BUSY;
        #1;
        n_checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL prio_turnaround: got ren %b iwait %b expected 0/1", ramREN, iwait); end
        tick();
        n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin n_fail++; $display("FAIL prio_ignt: got ren %b addr %h expected 1/200", ramREN, ramaddr); end
        $display("test_priority: data served first, fetch granted two cycles after completion");
        go_idle();
    endtask

    task automatic test_write;
        dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; ramstate = BUSY;
        tick();
        n_checks++; if ({ramWEN, ramREN} !== 2'b10) begin n_fail++; $display("FAIL write_strobes: got wen/ren %b expected 10", {ramWEN, ramREN}); end
        n_checks++; if (ramstore !== 32'h12345678 || ramaddr !== 32'h80) begin n_fail++; $display("FAIL write_data: got store %h addr %h expected 12345678/80", ramstore, ramaddr); end
        ramstate = ACCESS;
        #1;
        n_checks++; if (dwait !== 1'b0) begin n_fail++; $display("FAIL write_done: got dwait %b expected 0", dwait); end
        $display("test_write: write wins over read");
        tick();
        go_idle();
    endtask

    task automatic test_error;
        iREN = 1; iaddr = 32'h300; ramstate = ERROR;
        tick();
        n_checks++; if (iwait !== 1'b1 || ramREN !== 1'b1) begin n_fail++; $display("FAIL err_hold: got iwait %b ren %b expected 1/1", iwait, ramREN); end
        n_checks++; if (ram_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b expected 0", ram_err); end
        tick();
        ramstate = ACCESS; ramload = 32'hCAFE_F00D;
        #1;
        n_checks++; if (ram_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", ram_err); end
        n_checks++; if (iwait !== 1'b0 || iload !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL err_retry_done: got iwait %b iload %h expected 0/cafef00d", iwait, iload); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ram_err !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL err_after: got err %b ren %b expected 1/0", ram_err, ramREN); end
        $display("test_error: error retried and flagged");
        go_idle();
    endtask

    task automatic test_drop;
        iREN = 1; dREN = 1; iaddr = 32'h440; daddr = 32'h880; ramstate = BUSY;
        tick();
        n_checks++; if (dwait !== 1'b1 || ramaddr !== 32'h880) begin n_fail++; $display("FAIL drop_dgnt: got dwait %b addr %h expected 1/880", dwait, ramaddr); end
        dREN = 0;
        #1;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL drop_strobe: got ren %b expected 0", ramREN); end
        tick();
        n_checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL drop_idle: got ren %b iwait %b expected 0/1", ramREN, iwait); end
        tick();
        n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h440) begin n_fail++; $display("FAIL drop_ignt: got ren %b addr %h expected 1/440", ramREN, ramaddr); end
        $display("test_drop: dropped data request releases the RAM");
        go_idle();
    endtask

    task automatic test_reset_mid;
        iREN = 1; iaddr = 32'h700; ramstate = BUSY;
        tick();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got ren %b expected 1", ramREN); end
        #1;
        nRST = 0;
        #1;
        n_checks++; if (ramREN !== 1'b0 || ramaddr !== '0 || iwait !== 1'b1) begin n_fail++; $display("FAIL rstmid_async: got ren %b addr %h iwait %b expected 0/0/1", ramREN, ramaddr, iwait); end
        n_checks++; if (ram_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b expected 0", ram_err); end
        clear_inputs();
        @(negedge CLK);
        nRST = 1;
        $display("test_reset_mid: asynchronous reset drops strobes");
    endtask

    task automatic test_starve;
        int grants;
        int first_i;
        int exp_first_i;
        exp_first_i = STARVE_ON ? 5 : 0;
        grants = 0;
        first_i = 0;
        iREN = 1; dREN = 1; iaddr = 32'h500; daddr = 32'h600; ramstate = ACCESS;
        for (int c = 0; c < 40 && grants < 5; c++) begin
            tick();
            if (ramREN === 1'b1) begin
                grants++;
                if (ramaddr === 32'h500 && first_i == 0) first_i = grants;
            end
        end
        n_checks++; if (grants != 5) begin n_fail++; $display("FAIL starve_timeout: got %0d grants expected 5", grants); end
        n_checks++; if (first_i != exp_first_i) begin n_fail++; $display("FAIL starve_first_fetch: got grant %0d expected %0d", first_i, exp_first_i); end
        $display("test_starve: first fetch grant index %0d", first_i);
        go_idle();
    endtask

    task automatic test_random;
        int owner, owner_next, streak, r, done_cnt;
        bit err_m, dreq, stall_i;
        logic         e_iwait, e_dwait, e_ren, e_wen;
        logic [W-1:0] e_iload, e_dload, e_addr, e_store;
        nRST = 0;
        clear_inputs();
        #2;
        @(negedge CLK);
        nRST = 1;
        tick();
        owner = 0; streak = 0; err_m = 0; done_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            iREN = ($urandom_range(0, 3) != 0);
            dREN = ($urandom_range(0, 1) == 1);
            dWEN = ($urandom_range(0, 3) == 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 15);
            ramstate = (r < 5) ? FREE : (r < 9) ? BUSY : (r < 15) ? ACCESS : ERROR;
            #1;
            e_iwait = 1; e_dwait = 1; e_iload = '0; e_dload = '0;
            e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
            dreq = dREN || dWEN;
            if (owner == 2) begin
                e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
                if (ramstate == ACCESS) begin e_dwait = 0; e_dload = ramload; end
            end else if (owner == 1) begin
                e_addr = iaddr; e_ren = iREN;
                if (ramstate == ACCESS) begin e_iwait = 0; e_iload = ramload; end
            end
            n_checks++; if ({iwait, dwait, ramREN, ramWEN, ram_err} !== {e_iwait, e_dwait, e_ren, e_wen, err_m}) begin n_fail++; $display("FAIL rand_ctrl c%0d: got %b expected %b", c, {iwait, dwait, ramREN, ramWEN, ram_err}, {e_iwait, e_dwait, e_ren, e_wen, err_m}); end
            n_checks++; if (iload !== e_iload) begin n_fail++; $display("FAIL rand_iload c%0d: got %h expected %h", c, iload, e_iload); end
            n_checks++; if (dload !== e_dload) begin n_fail++; $display("FAIL rand_dload c%0d: got %h expected %h", c, dload, e_dload); end
            n_checks++; if (ramaddr !== e_addr) begin n_fail++; $display("FAIL rand_ramaddr c%0d: got %h expected %h", c, ramaddr, e_addr); end
            n_checks++; if (ramstore !== e_store) begin n_fail++; $display("FAIL rand_ramstore c%0d: got %h expected %h", c, ramstore, e_store); end

            owner_next = owner;
            stall_i = STARVE_ON && iREN && (streak == LIM);
            if (owner == 0) begin
                owner_next = stall_i ? 1 : dreq ? 2 : iREN ? 1 : 0;
            end else begin
                if (ramstate == ERROR) err_m = 1;
                if (ramstate == ACCESS) begin
                    done_cnt++;
                    $display("rand: %s access done at cycle %0d", (owner == 2) ? "data" : "inst", c);
                    if (owner == 1) streak = 0;
                    else if (!iREN) streak = 0;
                    else if (streak < LIM) streak++;
                    owner_next = 0;
                end else if ((owner == 2 && !dreq) || (owner == 1 && !iREN)) begin
                    owner_next = 0;
                end
            end
            owner = owner_next;
            tick();
        end
        $display("test_random: %0d completions modelled", done_cnt);
        go_idle();
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        test_reset();
        test_priority();
        test_write();
        test_error();
        test_drop();
        test_reset_mid();
        test_starve();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
